// File: rtl/vga_tile_compositor.sv
// ---------------------------------------------------------------------------
// vga_tile_compositor
//
// Walks an i_hcnt x i_vcnt raster. For every pixel it reads one tile word from
// an external map memory, plus one word from each sprite memory whose tile
// covers the pixel. It then composites the result with fixed sprite priority
// (index 0 wins) and colour-key transparency. Pixels are streamed as RGB444
// through a 2-entry valid/ready output FIFO, with sof/eol sideband bits.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   i_cfg_enable         run enable; low flushes all state on the next edge
//   i_hcnt, i_vcnt       active pixels per line / lines per frame
//   i_spr_bcol/brow/vis  per-sprite tile position and visibility (sprite 0 LSBs)
//   o_map_en/o_map_addr  map read strobe and {tile_row, tile_col}
//   i_map_data           map word, valid one cycle after o_map_en
//   o_spr_en/o_spr_addr  per-sprite read strobe and {off_row, off_col}
//   i_spr_data           sprite words, one-cycle latency
//   i_pix_ready          downstream ready
//   o_pix_valid/data     pixel stream (RGB444)
//   o_pix_sof/eol        first pixel of frame / last pixel of line
// ---------------------------------------------------------------------------
module vga_tile_compositor #(
    parameter int          TILE_LOG2     = 4,
    parameter int          MAP_COLS_LOG2 = 6,
    parameter int          MAP_ROWS_LOG2 = 6,
    parameter int          NUM_SPRITES   = 2,
    parameter logic [15:0] TRANSP_KEY    = 16'hF81F,
    parameter logic [11:0] BG_COLOR      = 12'h000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_cfg_enable,
    input  logic [11:0]                            i_hcnt,
    input  logic [11:0]                            i_vcnt,
    input  logic [NUM_SPRITES*MAP_COLS_LOG2-1:0]   i_spr_bcol,
    input  logic [NUM_SPRITES*MAP_ROWS_LOG2-1:0]   i_spr_brow,
    input  logic [NUM_SPRITES-1:0]                 i_spr_vis,
    output logic                                   o_map_en,
    output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] o_map_addr,
    input  logic [15:0]                            i_map_data,
    output logic [NUM_SPRITES-1:0]                 o_spr_en,
    output logic [NUM_SPRITES*2*TILE_LOG2-1:0]     o_spr_addr,
    input  logic [NUM_SPRITES*16-1:0]              i_spr_data,
    input  logic                                   i_pix_ready,
    output logic                                   o_pix_valid,
    output logic [11:0]                            o_pix_data,
    output logic                                   o_pix_sof,
    output logic                                   o_pix_eol
);

    localparam int SAW = 2 * TILE_LOG2;

    // Memory words carry RGB in their top 12 bits.
    function automatic logic [11:0] to_rgb444(input logic [15:0] d);
        return {d[15:12], d[11:8], d[7:4]};
    endfunction

    // Raster fetch position
    logic [11:0]            r_col;
    logic [11:0]            r_row;
    // Tags of the pixel whose memory data arrives this cycle
    logic                   r_inflight;
    logic                   r_tag_oom;
    logic                   r_tag_sof;
    logic                   r_tag_eol;
    logic [NUM_SPRITES-1:0] r_tag_hit;
    // Two-entry output FIFO
    logic [11:0]            r_fifo_rgb [2];
    logic [1:0]             r_fifo_sof;
    logic [1:0]             r_fifo_eol;
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;

    logic [11:0]            w_tile_col;
    logic [11:0]            w_tile_row;
    logic [TILE_LOG2-1:0]   w_off_col;
    logic [TILE_LOG2-1:0]   w_off_row;
    logic                   w_oom;
    logic                   w_pop;
    logic                   w_room;
    logic                   w_issue;
    logic [NUM_SPRITES-1:0] w_spr_hit;
    logic                   w_last_col;
    logic                   w_last_row;
    logic [11:0]            w_cap_rgb;

    assign o_pix_valid = (r_count != 2'd0);
    assign o_pix_data  = r_fifo_rgb[r_rd_ptr];
    assign o_pix_sof   = r_fifo_sof[r_rd_ptr];
    assign o_pix_eol   = r_fifo_eol[r_rd_ptr];
    assign w_pop       = o_pix_valid & i_pix_ready;

    // Fetch decision, pixel decomposition and memory strobes/addresses
    always_comb begin
        w_tile_col = r_col >> TILE_LOG2;
        w_tile_row = r_row >> TILE_LOG2;
        w_off_col  = r_col[TILE_LOG2-1:0];
        w_off_row  = r_row[TILE_LOG2-1:0];
        w_oom      = ({20'd0, w_tile_col} >= (32'd1 << MAP_COLS_LOG2)) ||
                     ({20'd0, w_tile_row} >= (32'd1 << MAP_ROWS_LOG2));
        w_last_col = (r_col >= i_hcnt - 12'd1);
        w_last_row = (r_row >= i_vcnt - 12'd1);
        // A fetch is only issued when its pixel is sure to find a FIFO slot.
        w_room     = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
        w_issue    = !rst && i_cfg_enable && (i_hcnt != 12'd0) && (i_vcnt != 12'd0) && w_room;
        o_map_en   = w_issue && !w_oom;
        o_map_addr = '0;
        if (o_map_en) begin
            o_map_addr = {w_tile_row[MAP_ROWS_LOG2-1:0], w_tile_col[MAP_COLS_LOG2-1:0]};
        end else begin
            o_map_addr = '0;
        end
        w_spr_hit  = '0;
        o_spr_en   = '0;
        o_spr_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_spr_hit[i] = i_spr_vis[i] &&
                ({20'd0, w_tile_col} == 32'(i_spr_bcol[i*MAP_COLS_LOG2 +: MAP_COLS_LOG2])) &&
                ({20'd0, w_tile_row} == 32'(i_spr_brow[i*MAP_ROWS_LOG2 +: MAP_ROWS_LOG2]));
            o_spr_en[i] = w_issue && w_spr_hit[i];
            o_spr_addr[i*SAW +: SAW] = o_spr_en[i] ? {w_off_row, w_off_col} : {SAW{1'b0}};
        end
    end

    // Composite the returning memory words; the lowest opaque sprite wins
    always_comb begin
        w_cap_rgb = r_tag_oom ? BG_COLOR : to_rgb444(i_map_data);
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            w_cap_rgb = (r_tag_hit[i] && (i_spr_data[i*16 +: 16] != TRANSP_KEY)) ?
                        to_rgb444(i_spr_data[i*16 +: 16]) : w_cap_rgb;
        end
    end

    // Raster counters and per-pixel tags for the outstanding fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= 12'd0;
            r_row      <= 12'd0;
            r_inflight <= 1'b0;
            r_tag_oom  <= 1'b0;
            r_tag_sof  <= 1'b0;
            r_tag_eol  <= 1'b0;
            r_tag_hit  <= '0;
        end else if (!i_cfg_enable) begin
            r_col      <= 12'd0;
            r_row      <= 12'd0;
            r_inflight <= 1'b0;
            r_tag_oom  <= 1'b0;
            r_tag_sof  <= 1'b0;
            r_tag_eol  <= 1'b0;
            r_tag_hit  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_oom <= w_oom;
                r_tag_sof <= (r_col == 12'd0) && (r_row == 12'd0);
                r_tag_eol <= w_last_col;
                r_tag_hit <= w_spr_hit;
                if (w_last_col) begin
                    r_col <= 12'd0;
                    r_row <= w_last_row ? 12'd0 : r_row + 12'd1;
                end else begin
                    r_col <= r_col + 12'd1;
                end
            end else begin
                r_tag_hit <= r_tag_hit;
            end
        end
    end

    // Output FIFO: push the composited pixel, pop on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_rgb[0] <= 12'd0;
            r_fifo_rgb[1] <= 12'd0;
            r_fifo_sof    <= 2'd0;
            r_fifo_eol    <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else if (!i_cfg_enable) begin
            r_fifo_rgb[0] <= 12'd0;
            r_fifo_rgb[1] <= 12'd0;
            r_fifo_sof    <= 2'd0;
            r_fifo_eol    <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_rgb[r_wr_ptr] <= w_cap_rgb;
                r_fifo_sof[r_wr_ptr] <= r_tag_sof;
                r_fifo_eol[r_wr_ptr] <= r_tag_eol;
                r_wr_ptr             <= ~r_wr_ptr;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: doc/vga_tile_compositor.md
Name: vga_tile_compositor

Overview:
- Parametrised successor of the single-player/single-exit frame generator.
- Walks a configurable raster and fetches one map tile colour per TILE×TILE block from an external map memory.
- Overlays NUM_SPRITES tile-sized sprites with fixed priority and colour-key transparency.
- Streams 12-bit RGB with true valid/ready backpressure and sof/eol sideband to the VGA timing/FIFO stage.

Parameters:
- TILE_LOG2, 4, log2 of tile edge in pixels; a tile is 2^TILE_LOG2 square.
- MAP_COLS_LOG2, 6, log2 of map width in tiles.
- MAP_ROWS_LOG2, 6, log2 of map height in tiles.
- NUM_SPRITES, 2, number of sprite layers (1..8); index 0 has highest priority.
- TRANSP_KEY, 16'hF81F, sprite memory word treated as transparent.
- BG_COLOR, 12'h000, colour for pixels outside the map.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_cfg_enable  in  1  run enable; low = synchronous flush
- i_hcnt  in  12  active pixels per line; stable while enabled
- i_vcnt  in  12  active lines per frame; stable while enabled
- i_spr_bcol  in  NUM_SPRITES*MAP_COLS_LOG2  sprite tile column, packed, sprite 0 in LSBs
- i_spr_brow  in  NUM_SPRITES*MAP_ROWS_LOG2  sprite tile row, packed
- i_spr_vis  in  NUM_SPRITES  per-sprite visible flag
- o_map_en  out  1  map memory read strobe
- o_map_addr  out  MAP_ROWS_LOG2+MAP_COLS_LOG2  {tile_row, tile_col}
- i_map_data  in  16  map word; valid exactly 1 cycle after o_map_en
- o_spr_en  out  NUM_SPRITES  per-sprite read strobe
- o_spr_addr  out  NUM_SPRITES*2*TILE_LOG2  {offset_row, offset_col} per sprite
- i_spr_data  in  NUM_SPRITES*16  sprite words; 1-cycle latency
- i_pix_ready  in  1  downstream ready
- o_pix_valid  out  1  pixel valid
- o_pix_data  out  12  RGB444
- o_pix_sof  out  1  pixel is (col 0, row 0)
- o_pix_eol  out  1  pixel is col i_hcnt-1

Behaviour:
- Reset: all outputs 0; fetch counters col = 0, row = 0; output buffer empty; inflight = 0.
- Raster (zero-based): fetch counter advances on each issued fetch. col wraps at i_hcnt-1 to 0 and row increments; row wraps at i_vcnt-1 to 0.
- If i_hcnt == 0 or i_vcnt == 0: no fetch issued and o_pix_valid stays 0.
- Decomposition:
  - tile_col = col >> TILE_LOG2; off_col = col[TILE_LOG2-1:0]; same for row.
  - Pixel is out-of-map if tile_col ≥ 2^MAP_COLS_LOG2 or tile_row ≥ 2^MAP_ROWS_LOG2.
- Fetch issue (cycle t):
  - Issue allowed when enabled and count + inflight − pop < 2, where count = output-buffer occupancy, inflight ∈ {0,1}, pop = o_pix_valid & i_pix_ready.
  - On issue: o_map_en = 1 unless out-of-map.
  - o_spr_en[i] = 1 iff i_spr_vis[i] and tile matches sprite i.
  - Addresses are driven in the same cycle; sprite addresses are 0 when the strobe is low.
  - Strobes are 0 when no fetch is issued.
- Capture (cycle t+1), per-pixel tags carried from t:
  - Select the lowest i with a sprite hit whose data ≠ TRANSP_KEY.
  - Else map data, or BG_COLOR if out-of-map.
  - 16→12 conversion: {d[15:12], d[11:8], d[7:4]}.
  - Push {rgb, sof, eol} into a 2-entry output FIFO.
- Latency: fetch at t → o_pix_valid no earlier than t+2. Throughput is 1 pixel/clk while i_pix_ready is held high.
- Output: FIFO head drives o_pix_*. Data is held stable while valid & !ready. Push and pop in the same cycle keep count unchanged. No pixel is ever dropped or duplicated.
- Sprite inputs are sampled at fetch time. Mid-frame changes take effect from the next fetched pixel; there is no tearing protection at this level.
- i_cfg_enable low: next edge clears counters, FIFO and inflight. In-flight memory data is discarded; o_pix_valid = 0 from that edge. Re-enable restarts at (0,0) with sof.
- Async rst mid-stream: all state cleared immediately; o_pix_valid drops without waiting for a clock.

Test Plan:
- i_hcnt = 32, i_vcnt = 32, map word at addr 0 = 16'hF0F0, ready held high → first pixel valid 2 cycles after enable, data 12'hF0F, sof = 1. 32×32 pixels per frame; eol on every 32nd pixel; sof recurs after 1024 pixels.
- Sprite 0 at tile (1,0), sprite data 16'h1230 everywhere, visible → pixels col 16..31, row 0..15 = 12'h123; all others map colour.
- Sprites 0 and 1 on the same tile; sprite 0 word = TRANSP_KEY at offset (0,0), sprite 1 = 16'hABC0 → pixel (0,0) of that tile = 12'hABC; other pixels show sprite 0.
- Toggle i_pix_ready in the pattern 1,0,0,1,0,1,… over 100 pixels → scoreboard shows an in-order, gap-free pixel sequence; data stable during stalls; count never exceeds 2.
- i_hcnt = 1100 with MAP_COLS_LOG2 = 6 → cols ≥ 1024 give BG_COLOR and o_map_en stays 0 for them.
- Deassert i_cfg_enable mid-line with a full FIFO, then reassert → o_pix_valid = 0 the next cycle; first pixel after restart carries sof = 1 and the map tile (0,0) colour.
